// File: rtl/rps_match_engine.sv
// rps_match_engine: first-to-WIN_TARGET match of an odd-sized cyclic
// rock-paper-scissors game with debounced move buttons.
//
// Ports:
//   CLK            system clock
//   RST            synchronous active-high reset
//   btn            raw move buttons, active-high, bit i = move i
//   result         {tie, computer, person}; 011/100 idle blink, 000/winner at match end
//   person_score   person's rounds won (saturates at WIN_TARGET)
//   computer_score computer's rounds won (saturates at WIN_TARGET)
//   comp_choice    computer's move for the last evaluated round
//   match_over     high while the match-end display is active
//
// Optional build macro: RPS_LFSR_EN -- a 16-bit LFSR makes the choice
// counter occasionally skip a value so the computer's move is harder to time.
`timescale 1ns/1ps
module rps_match_engine #(
    parameter int unsigned NUM_CHOICES     = 3,
    parameter int unsigned WIN_TARGET      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned SHOW_CYCLES     = 12000000,
    parameter int unsigned BLINK_CYCLES    = 3000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_CHOICES-1:0] btn,
    output logic [2:0]             result,
    output logic [3:0]             person_score,
    output logic [3:0]             computer_score,
    output logic [3:0]             comp_choice,
    output logic                   match_over
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SHOW_W  = $clog2(SHOW_CYCLES + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [2:0] RES_PERSON = 3'b001;
    localparam logic [2:0] RES_COMP   = 3'b010;
    localparam logic [2:0] RES_TIE    = 3'b100;
    localparam logic [2:0] RES_IDLE   = 3'b011;
    localparam logic [2:0] RES_OFF    = 3'b000;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SHOW, S_END} state_e;

    logic [NUM_CHOICES-1:0] sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [DB_W-1:0]        db_cnt_q [NUM_CHOICES];
    logic [DB_W-1:0]        db_cnt_d [NUM_CHOICES];
    logic                   any_db_q, any_db_d, press_evt_q, press_evt_d, any_db;
    logic [3:0]             choice_q, choice_d;
    logic [4:0]             choice_sum, step;
    logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                   blink_q, blink_d;
    state_e                 state_q, state_d;
    logic [3:0]             person_mv_q, person_mv_d, comp_mv_q, comp_mv_d, pmove;
    logic [SHOW_W-1:0]      show_cnt_q, show_cnt_d;
    logic                   pend_clr_q, pend_clr_d;
    logic [2:0]             result_q, result_d, round_res, idle_pat, end_pat;
    logic [3:0]             pscore_q, pscore_d, cscore_q, cscore_d;
    logic [3:0]             comp_choice_q, comp_choice_d;
    logic                   match_over_q, match_over_d;
    logic [4:0]             diff_raw, diff;
`ifdef RPS_LFSR_EN
    logic [15:0]            lfsr_q, lfsr_d;
`endif

    // Synchroniser, per-bit debounce and press edge detection
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < NUM_CHOICES; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        any_db      = |db_q;
        any_db_d    = any_db;
        press_evt_d = any_db & ~any_db_q;
    end

    // Free-running choice counter and blink generator
    always_comb begin
`ifdef RPS_LFSR_EN
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        step   = lfsr_q[0] ? 5'd2 : 5'd1;
`else
        step   = 5'd1;
`endif
        choice_sum = 5'(choice_q) + step;
        if (choice_sum >= 5'(NUM_CHOICES)) begin
            choice_sum = choice_sum - 5'(NUM_CHOICES);
        end
        choice_d = choice_sum[3:0];

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Lowest-index held button is the person's move
    always_comb begin
        pmove = '0;
        for (int i = NUM_CHOICES - 1; i >= 0; i--) begin
            if (db_q[i]) pmove = 4'(i);
        end
    end

    // Cyclic win rule: odd distance means the person wins
    always_comb begin
        diff_raw = 5'(person_mv_q) + 5'(NUM_CHOICES) - 5'(comp_mv_q);
        diff     = (diff_raw >= 5'(NUM_CHOICES)) ? diff_raw - 5'(NUM_CHOICES) : diff_raw;
        if (diff == 5'd0)   round_res = RES_TIE;
        else if (diff[0])   round_res = RES_PERSON;
        else                round_res = RES_COMP;
    end

    // Match FSM next state; display patterns use next blink so they line up with it
    always_comb begin
        state_d       = state_q;
        person_mv_d   = person_mv_q;
        comp_mv_d     = comp_mv_q;
        show_cnt_d    = show_cnt_q;
        pend_clr_d    = pend_clr_q;
        result_d      = result_q;
        pscore_d      = pscore_q;
        cscore_d      = cscore_q;
        comp_choice_d = comp_choice_q;
        idle_pat      = blink_d ? RES_TIE : RES_IDLE;
        end_pat       = blink_d ? RES_OFF
                      : ((pscore_q == 4'(WIN_TARGET)) ? RES_PERSON : RES_COMP);
        case (state_q)
            S_IDLE: begin
                result_d = idle_pat;
                if (press_evt_q) begin
                    person_mv_d = pmove;
                    comp_mv_d   = choice_q;
                    state_d     = S_EVAL;
                end
            end
            S_EVAL: begin
                result_d      = round_res;
                comp_choice_d = comp_mv_q;
                if (round_res == RES_PERSON && pscore_q != 4'(WIN_TARGET)) pscore_d = pscore_q + 4'd1;
                if (round_res == RES_COMP && cscore_q != 4'(WIN_TARGET))   cscore_d = cscore_q + 4'd1;
                show_cnt_d = '0;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                if (show_cnt_q != SHOW_W'(SHOW_CYCLES - 1)) begin
                    show_cnt_d = show_cnt_q + SHOW_W'(1);
                end else if (!any_db) begin
                    if (pscore_q == 4'(WIN_TARGET) || cscore_q == 4'(WIN_TARGET)) begin
                        state_d  = S_END;
                        result_d = end_pat;
                    end else begin
                        state_d  = S_IDLE;
                        result_d = idle_pat;
                    end
                end
            end
            S_END: begin
                result_d = end_pat;
                if (press_evt_q) pend_clr_d = 1'b1;
                // Scores clear only once the acknowledging press is released
                if (pend_clr_q && !any_db) begin
                    pend_clr_d = 1'b0;
                    pscore_d   = '0;
                    cscore_d   = '0;
                    state_d    = S_IDLE;
                    result_d   = idle_pat;
                end
            end
            default: state_d = S_IDLE;
        endcase
        match_over_d = (state_d == S_END);
    end

    // All state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            db_q          <= '0;
            for (int i = 0; i < NUM_CHOICES; i++) db_cnt_q[i] <= '0;
            any_db_q      <= 1'b0;
            press_evt_q   <= 1'b0;
            choice_q      <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            state_q       <= S_IDLE;
            person_mv_q   <= '0;
            comp_mv_q     <= '0;
            show_cnt_q    <= '0;
            pend_clr_q    <= 1'b0;
            result_q      <= RES_IDLE;
            pscore_q      <= '0;
            cscore_q      <= '0;
            comp_choice_q <= '0;
            match_over_q  <= 1'b0;
`ifdef RPS_LFSR_EN
            lfsr_q        <= 16'hACE1;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_q          <= db_d;
            for (int i = 0; i < NUM_CHOICES; i++) db_cnt_q[i] <= db_cnt_d[i];
            any_db_q      <= any_db_d;
            press_evt_q   <= press_evt_d;
            choice_q      <= choice_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            state_q       <= state_d;
            person_mv_q   <= person_mv_d;
            comp_mv_q     <= comp_mv_d;
            show_cnt_q    <= show_cnt_d;
            pend_clr_q    <= pend_clr_d;
            result_q      <= result_d;
            pscore_q      <= pscore_d;
            cscore_q      <= cscore_d;
            comp_choice_q <= comp_choice_d;
            match_over_q  <= match_over_d;
`ifdef RPS_LFSR_EN
            lfsr_q        <= lfsr_d;
`endif
        end
    end

    assign result         = result_q;
    assign person_score   = pscore_q;
    assign computer_score = cscore_q;
    assign comp_choice    = comp_choice_q;
    assign match_over     = match_over_q;

endmodule

// File: tb/tb_rps_match_engine.sv
// Bench for rps_match_engine with N=3, first-to-2, short debounce/show/blink.
`timescale 1ns/1ps
module tb_rps_match_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic [2:0] result;
    logic [3:0] person_score, computer_score, comp_choice;
    logic       match_over;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ps    = 0;
    int cs    = 0;

    rps_match_engine #(
        .NUM_CHOICES(3), .WIN_TARGET(2), .DEBOUNCE_CYCLES(4),
        .SHOW_CYCLES(16), .BLINK_CYCLES(8)
    ) dut (
        .CLK(clk), .RST(rst), .btn(btn), .result(result),
        .person_score(person_score), .computer_score(computer_score),
        .comp_choice(comp_choice), .match_over(match_over)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; blink and choice counter derive from it
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [2:0] idle_exp(input int c);
        return ((c / 8) % 2 == 1) ? 3'b100 : 3'b011;
    endfunction

    function automatic logic [2:0] end_exp(input int c);
        logic [2:0] w;
        w = (ps == 2) ? 3'b001 : 3'b010;
        return ((c / 8) % 2 == 1) ? 3'b000 : w;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_result"}, 8'(result), 8'(idle_exp(cyc)));
        chk({tag, "_mo"}, 8'(match_over), 8'd0);
        chk({tag, "_ps"}, 8'(person_score), 8'(ps));
        chk({tag, "_cs"}, 8'(computer_score), 8'(cs));
    endtask

    task automatic idle_gap(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            chk_idle(tag);
        end
    endtask

    task automatic chk_end(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            chk({tag, "_mo"}, 8'(match_over), 8'd1);
            chk({tag, "_result"}, 8'(result), 8'(end_exp(cyc)));
            chk({tag, "_ps"}, 8'(person_score), 8'(ps));
            chk({tag, "_cs"}, 8'(computer_score), 8'(cs));
        end
    endtask

    // One round: press b at this negedge, hold it hold cycles (>=9), predict outcome
    task automatic round(input logic [2:0] b, input int hold, input string tag);
        int c, comp, p, d, ex;
        logic [2:0] exp_res;
        c    = cyc;
        btn  = b;
        comp = (c + 7) % 3;
        p    = b[0] ? 0 : (b[1] ? 1 : 2);
        d    = (p - comp + 3) % 3;
        if (d == 0) exp_res = 3'b100;
        else if (d % 2 == 1) begin exp_res = 3'b001; if (ps < 2) ps++; end
        else begin exp_res = 3'b010; if (cs < 2) cs++; end
        repeat (8) tick();
        chk({tag, "_eval_cycle"}, 8'(result), 8'(idle_exp(cyc)));
        tick();
        chk({tag, "_res"}, 8'(result), 8'(exp_res));
        chk({tag, "_comp"}, 8'(comp_choice), 8'(comp));
        chk({tag, "_ps"}, 8'(person_score), 8'(ps));
        chk({tag, "_cs"}, 8'(computer_score), 8'(cs));
        repeat (hold - 9) tick();
        btn = 3'b000;
        ex = (c + 25 > c + hold + 7) ? c + 25 : c + hold + 7;
        while (cyc < ex - 1) tick();
        chk({tag, "_held"}, 8'(result), 8'(exp_res));
        tick();
        if (ps == 2 || cs == 2) begin
            chk({tag, "_end_mo"}, 8'(match_over), 8'd1);
            chk({tag, "_end_res"}, 8'(result), 8'(end_exp(cyc)));
        end else begin
            chk_idle({tag, "_back"});
        end
    endtask

    task automatic press_for_comp(input int t, input logic [2:0] b, input int hold, input string tag);
        while ((cyc + 7) % 3 != t) begin
            tick();
            chk_idle({tag, "_wait"});
        end
        round(b, hold, tag);
    endtask

    // Acknowledge match end: press, hold, release, expect cleared IDLE
    task automatic end_exit(input int hold, input string tag);
        int c;
        c   = cyc;
        btn = 3'b001;
        repeat (hold) begin
            tick();
            chk({tag, "_frozen_mo"}, 8'(match_over), 8'd1);
            chk({tag, "_frozen_ps"}, 8'(person_score), 8'(ps));
        end
        btn = 3'b000;
        while (cyc < c + hold + 6) begin
            tick();
            chk({tag, "_rel_mo"}, 8'(match_over), 8'd1);
            chk({tag, "_rel_res"}, 8'(result), 8'(end_exp(cyc)));
        end
        ps = 0;
        cs = 0;
        tick();
        chk_idle({tag, "_cleared"});
    endtask

    initial begin
        int t, p, hold, nr;
        logic [2:0] b;
        rst = 1'b1;
        btn = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_result", 8'(result), 8'h03);
        chk("rst_ps", 8'(person_score), 8'd0);
        chk("rst_cs", 8'(computer_score), 8'd0);
        chk("rst_comp", 8'(comp_choice), 8'd0);
        chk("rst_mo", 8'(match_over), 8'd0);

        idle_gap(20, "blink");

        // Too-short press must not register
        btn = 3'b001;
        repeat (3) tick();
        btn = 3'b000;
        idle_gap(20, "short");

        // Paper vs rock, held past the show time
        press_for_comp(0, 3'b010, 30, "paper");
        // Simultaneous 110 against paper: move 1 wins priority, tie
        press_for_comp(1, 3'b110, 12, "prio");

        // Random rounds until someone takes the match
        nr = 0;
        while (ps < 2 && cs < 2 && nr < 20) begin
            idle_gap($urandom_range(0, 6), "rgap");
            if ($urandom_range(0, 9) < 7) b = 3'(1 << $urandom_range(0, 2));
            else                          b = 3'($urandom_range(1, 7));
            round(b, $urandom_range(9, 30), "rnd");
            nr++;
        end
        if (ps == 2 || cs == 2) begin
            chk_end(16, "rend");
            end_exit(12, "rexit");
        end

        // Directed match: two person wins
        for (int k = 0; k < 2; k++) begin
            idle_gap($urandom_range(0, 5), "dgap");
            t = $urandom_range(0, 2);
            p = (t + 1) % 3;
            b = 3'(1 << p);
            hold = $urandom_range(9, 20);
            press_for_comp(t, b, hold, "dwin");
        end
        chk("dwin_ps2", 8'(person_score), 8'd2);
        chk_end(16, "dend");
        end_exit(10, "dexit");

        // Reset during SHOW
        idle_gap(3, "pre_rst");
        while ((cyc + 7) % 3 != 0) tick();
        btn = 3'b010;
        repeat (12) tick();
        chk("show_res", 8'(result), 8'h01);
        chk("show_ps", 8'(person_score), 8'd1);
        btn = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ps = 0;
        cs = 0;
        chk("rst2_result", 8'(result), 8'h03);
        chk("rst2_ps", 8'(person_score), 8'd0);
        chk("rst2_cs", 8'(computer_score), 8'd0);
        chk("rst2_comp", 8'(comp_choice), 8'd0);
        chk("rst2_mo", 8'(match_over), 8'd0);
        idle_gap(20, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rps_match_engine.md
Name: rps_match_engine

Overview:
- Parametrised successor to the board-level rock-paper-scissors game.
- Generalises to any odd number of choices (RPS, RPS-lizard-Spock, ...).
- Adds debounced inputs, a first-to-N match with per-player scores, a timed result display and a match-end state.
- Sits between the iCEBreaker buttons/PMOD inputs (inverted externally to active-high) and the LED/PMOD result outputs.

Parameters:
- NUM_CHOICES, 3: number of moves; odd, 3..15.
- WIN_TARGET, 3: rounds needed to win the match; 1..15.
- DEBOUNCE_CYCLES, 120000: cycles an input must be stable before its change is accepted (10 ms at 12 MHz).
- SHOW_CYCLES, 12000000: minimum cycles a round result is held.
- BLINK_CYCLES, 3000000: half-period of idle and match-end blink patterns.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- btn  in  NUM_CHOICES  raw asynchronous move buttons, active-high; bit i = move i.
- result  out  3  {tie, computer, person}: 001 person wins, 010 computer wins, 100 tie.
- person_score  out  4  person's rounds won.
- computer_score  out  4  computer's rounds won.
- comp_choice  out  4  computer's move for the last evaluated round.
- match_over  out  1  high while in MATCH_END.

Behaviour:
- Reset values (RST high at a rising CLK edge):
  - All registers cleared; state IDLE.
  - result=011; scores=0; comp_choice=0; match_over=0.
  - Blink, show and debounce counters =0; choice counter =0.
  - Reset mid-round or mid-match abandons the round and clears the scores.
- Input conditioning, per bit:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced bit changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - any_db = OR of the debounced bits.
  - press_evt = registered rising edge of any_db.
- Choice counter:
  - Free-running mod-NUM_CHOICES counter, advances every cycle; wraps NUM_CHOICES-1 -> 0.
  - Running from reset, so its value is deterministic.
- Move encoding and win rule:
  - Moves are 0..NUM_CHOICES-1 in cyclic order.
  - d = (person - computer) mod NUM_CHOICES.
  - d=0 is a tie; d odd means person wins; d even and nonzero means computer wins.
- Blink pattern: blink toggles every BLINK_CYCLES; the counter free-runs in all states.
- IDLE:
  - result = 011 while blink=0, 100 while blink=1.
  - On press_evt: person move = lowest-index debounced-high bit; computer move = choice counter value that same cycle; go to EVAL.
- EVAL, one cycle:
  - Register result, comp_choice and the winner's score increment; ties do not score. Results appear on outputs the cycle after EVAL.
  - Go to SHOW; clear the show counter.
- SHOW:
  - Hold result.
  - Leave only when the show counter has reached SHOW_CYCLES-1 AND any_db=0. Buttons still held extend the display.
  - If either score equals WIN_TARGET, go to MATCH_END; otherwise go to IDLE.
  - press_evt is ignored.
- MATCH_END:
  - match_over=1.
  - result = winner code (001 or 010) while blink=0, 000 while blink=1.
  - Scores frozen.
  - On press_evt, wait for any_db=0, then clear scores and go to IDLE.
- Width rule: scores saturate at WIN_TARGET, so they never wrap.
- Simultaneous presses: the lowest index wins (move 0 has priority).
- Presses during the debounce window or in non-IDLE states do not queue.

Optional Feature:
- Macro: RPS_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) steps every cycle.
  - The choice counter advances by 2 instead of 1 (mod NUM_CHOICES) on cycles where LFSR bit 0 = 1.
  - This makes the computer's move less predictable from press timing.
- Undefined: advance is always 1; no LFSR logic is present.
- Ports are identical in both builds.

Test Plan:
Bench parameters: NUM_CHOICES=3, WIN_TARGET=2, DEBOUNCE_CYCLES=4, SHOW_CYCLES=16, BLINK_CYCLES=8, RPS_LFSR_EN undefined.
- Reset then hold idle: result = 011 for 8 cycles, 100 for 8 cycles, repeating; scores 0; match_over 0.
- btn=001 held 3 cycles then released: no press_evt; state stays IDLE; scores unchanged.
- Press btn[1] (paper) timed so comp_choice=0 (rock): result=001, person_score=1. Held result persists while the button stays down past 16 cycles, then IDLE after release.
- btn=110 pressed together while comp_choice=1: person move=1 (priority), result=100 (tie), scores unchanged.
- Two person wins: after the second SHOW, match_over=1, result alternates 001/000. Press+release returns to IDLE with scores=0.
- Assert RST during SHOW with person_score=1: next cycle result=011, scores=0, state IDLE.
